// File: rtl/cache_memory_arbiter.sv
// Serialises line-fill reads from an instruction cache (requester 0) and a data cache
// (requester 1) onto one memory port. Define ARB_ROUND_ROBIN_EN for round-robin tie-break.

module cache_memory_arbiter_checker #(
  parameter int ADDR_WIDTH = 6
) (
  input logic                  clock,
  input logic                  reset,
  input logic                  memory_read_enable,
  input logic [ADDR_WIDTH-1:0] memory_address,
  input logic                  busy,
  input logic                  req0_read_ready,
  input logic                  req1_read_ready
);

  a_single_ready: assert property (@(posedge clock) disable iff (!reset)
    !(req0_read_ready && req1_read_ready));

  a_command_one_cycle: assert property (@(posedge clock) disable iff (!reset)
    memory_read_enable |=> !memory_read_enable);

  a_command_when_busy: assert property (@(posedge clock) disable iff (!reset)
    memory_read_enable |-> busy);

  a_idle_quiet: assert property (@(posedge clock) disable iff (!reset)
    !busy |-> (memory_address == {ADDR_WIDTH{1'b0}}) && !memory_read_enable);

endmodule

module cache_memory_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_read_enable,
  input  logic [ADDR_WIDTH-1:0] req0_address,
  output logic                  req0_read_ready,
  output logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_read_enable,
  input  logic [ADDR_WIDTH-1:0] req1_address,
  output logic                  req1_read_ready,
  output logic [DATA_WIDTH-1:0] req1_data,
  output logic                  memory_read_enable,
  output logic [ADDR_WIDTH-1:0] memory_address,
  input  logic                  memory_read_ready,
  input  logic [DATA_WIDTH-1:0] memory_data,
  output logic                  grant,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                state;
  logic                  pending0;
  logic                  pending1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic                  owner;
  logic                  last_grant;

  logic                  complete;
  logic                  clear0;
  logic                  clear1;
  logic                  take0;
  logic                  take1;
  logic                  winner;
  logic [ADDR_WIDTH-1:0] winner_addr;

`ifndef ARB_ROUND_ROBIN_EN
  // Fixed priority keeps last_grant as state only; this tap marks it intentionally unread.
  logic                  unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // Completion, capture qualification and arbitration decode
  always_comb begin
    complete    = 1'b0;
    winner      = 1'b0;
    winner_addr = {ADDR_WIDTH{1'b0}};
    if ((state == WAIT) && memory_read_ready) begin
      complete = 1'b1;
    end else begin
      complete = 1'b0;
    end
    clear0 = complete && (owner == 1'b0);
    clear1 = complete && (owner == 1'b1);
    // A slot that completes this cycle is free to take the next miss immediately.
    take0  = req0_read_enable && (!pending0 || clear0);
    take1  = req1_read_enable && (!pending1 || clear1);
    if (pending0 && pending1) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = ~last_grant;
`else
      winner = 1'b0;
`endif
    end else if (pending1) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
    if (winner) begin
      winner_addr = addr1;
    end else begin
      winner_addr = addr0;
    end
  end

  // Per-requester pending flag and latched line address
  always_ff @(posedge clock) begin
    if (!reset) begin
      pending0 <= 1'b0;
      pending1 <= 1'b0;
      addr0    <= {ADDR_WIDTH{1'b0}};
      addr1    <= {ADDR_WIDTH{1'b0}};
    end else begin
      if (take0) begin
        pending0 <= 1'b1;
        addr0    <= req0_address;
      end else if (clear0) begin
        pending0 <= 1'b0;
      end
      if (take1) begin
        pending1 <= 1'b1;
        addr1    <= req1_address;
      end else if (clear1) begin
        pending1 <= 1'b0;
      end
    end
  end

  // Transaction FSM with registered memory command, grant and busy
  always_ff @(posedge clock) begin
    if (!reset) begin
      state              <= IDLE;
      owner              <= 1'b0;
      last_grant         <= 1'b1;
      memory_read_enable <= 1'b0;
      memory_address     <= {ADDR_WIDTH{1'b0}};
      grant              <= 1'b0;
      busy               <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pending0 || pending1) begin
            state              <= ISSUE;
            owner              <= winner;
            grant              <= winner;
            memory_read_enable <= 1'b1;
            memory_address     <= winner_addr;
            busy               <= 1'b1;
          end
        end
        ISSUE: begin
          state              <= WAIT;
          memory_read_enable <= 1'b0;
        end
        WAIT: begin
          if (memory_read_ready) begin
            state          <= IDLE;
            last_grant     <= owner;
            memory_address <= {ADDR_WIDTH{1'b0}};
            busy           <= 1'b0;
          end
        end
        default: begin
          state              <= IDLE;
          memory_read_enable <= 1'b0;
          memory_address     <= {ADDR_WIDTH{1'b0}};
          busy               <= 1'b0;
        end
      endcase
    end
  end

  // Ready must land in the same cycle as the memory pulse, so it stays combinational.
  assign req0_read_ready = (state == WAIT) && (owner == 1'b0) && memory_read_ready;
  assign req1_read_ready = (state == WAIT) && (owner == 1'b1) && memory_read_ready;
  assign req0_data       = memory_data;
  assign req1_data       = memory_data;

  cache_memory_arbiter_checker #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_checker (
    .clock              (clock),
    .reset              (reset),
    .memory_read_enable (memory_read_enable),
    .memory_address     (memory_address),
    .busy               (busy),
    .req0_read_ready    (req0_read_ready),
    .req1_read_ready    (req1_read_ready)
  );

endmodule
